// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Active-low 7-segment codes and converter FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

   // Segment order is {g,f,e,d,c,b,a}; a lit segment is driven low.
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] SEG_MINUS  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK  = 7'b1111111;

   localparam logic [3:0] CODE_MINUS = 4'hA;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      FORMAT  = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/seg7_digit.sv
// ============================================================================
// Module   : seg7_digit
// Purpose  : Combinational 4-bit code to active-low segment lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_digit
   import seg7_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      for (int d = 0; d < 10; d++) begin
         if (code_i == 4'(d)) seg_o = SEG_DIGIT[d];
      end
      if (code_i == CODE_MINUS) seg_o = SEG_MINUS;
   end

endmodule

`default_nettype wire

// File: rtl/signed_decimal_display.sv
// ============================================================================
// Module   : signed_decimal_display
// Purpose  : Signed/unsigned binary to multi-digit 7-segment display via an
//            iterative double-dabble converter with leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_decimal_display
   import seg7_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SIGNED   = 1,
   parameter int BLANK_LZ = 1
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      in_ready,
   output logic                      busy,
   output logic                      out_valid,
   output logic [(DIGITS+1)*7-1:0]   hex
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   state_e                    state_q, state_d;
   logic                      neg_q, neg_d;
   logic [WIDTH-1:0]          mag_q, mag_d;
   logic [BW-1:0]             bcd_q, bcd_d, bcd_adj;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [(DIGITS+1)*7-1:0]   hex_q, hex_d, segs;
   logic                      out_valid_q;
   logic [3:0]                codes [0:DIGITS];

   assign in_ready  = (state_q == IDLE) & ~reset;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign hex       = hex_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         neg_q       <= 1'b0;
         mag_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         hex_q       <= '1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         neg_q       <= neg_d;
         mag_q       <= mag_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         hex_q       <= hex_d;
         out_valid_q <= (state_q == FORMAT);
      end
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      hex_d   = hex_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               neg_d   = (SIGNED != 0) && in_data[WIDTH-1];
               mag_d   = neg_d ? (~in_data + WIDTH'(1)) : in_data;
               bcd_d   = '0;
               cnt_d   = CW'(WIDTH);
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
            mag_d = {mag_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FORMAT;
         end
         FORMAT: begin
            hex_d   = segs;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Highest nonzero digit sets how many digits show and where the sign floats.
   always_comb begin
      int top;
      top = 0;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] != 4'd0) top = k;
      end
      for (int k = 0; k <= DIGITS; k++) codes[k] = CODE_BLANK;
      for (int k = 0; k < DIGITS; k++) begin
         if (BLANK_LZ == 0 || k <= top) codes[k] = bcd_q[4*k +: 4];
         else if (neg_q && k == top + 1) codes[k] = CODE_MINUS;
      end
      if (neg_q && (BLANK_LZ == 0 || top == DIGITS - 1)) codes[DIGITS] = CODE_MINUS;
   end

   for (genvar k = 0; k <= DIGITS; k++) begin : g_digit
      seg7_digit u_digit (
         .code_i (codes[k]),
         .seg_o  (segs[7*k +: 7])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_signed_decimal_display.sv
// ============================================================================
// Module   : tb_signed_decimal_display
// Purpose  : Directed self-checking bench over four parameterisations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signed_decimal_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
   localparam logic [6:0] MI = 7'b0111111, BL = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data8 = 8'd0;
   logic [11:0] in_data12 = 12'd0;

   logic rdy0, rdy1, rdy2, rdy3, busy0, busy1, busy2, busy3, ov0, ov1, ov2, ov3;
   logic [27:0] hex0, hex1, hex2;
   logic [34:0] hex3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   signed_decimal_display #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .BLANK_LZ(1)) d0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data8),
      .in_ready(rdy0), .busy(busy0), .out_valid(ov0), .hex(hex0));
   signed_decimal_display #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .BLANK_LZ(0)) d1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data8),
      .in_ready(rdy1), .busy(busy1), .out_valid(ov1), .hex(hex1));
   signed_decimal_display #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .BLANK_LZ(1)) d2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data8),
      .in_ready(rdy2), .busy(busy2), .out_valid(ov2), .hex(hex2));
   signed_decimal_display #(.WIDTH(12), .DIGITS(4), .SIGNED(1), .BLANK_LZ(1)) d3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data12),
      .in_ready(rdy3), .busy(busy3), .out_valid(ov3), .hex(hex3));

   // One-cycle request to every instance; latencies counted in edges after accept.
   task automatic xfer(input logic [7:0] d8, input logic [11:0] d12,
                       output int lat0, output int lat3);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data8  = d8;
      in_data12 = d12;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat0 = -1;
      lat3 = -1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (ov0 && lat0 < 0) lat0 = i;
         if (ov3 && lat3 < 0) lat3 = i;
         if (lat0 >= 0 && lat3 >= 0) break;
      end
   endtask

   task automatic test_reset;
      in_valid = 1'b1;
      in_data8 = 8'd42;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (hex0 !== {4{BL}}) begin failures++; $display("FAIL reset_hex0 got=%b exp=%b", hex0, {4{BL}}); end
      checks++; if (hex3 !== {5{BL}}) begin failures++; $display("FAIL reset_hex3 got=%b exp=%b", hex3, {5{BL}}); end
      checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
      checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", rdy0); end
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", rdy0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_no_accept busy=%b exp=0", busy0); end
   endtask

   task automatic test_zero;
      int l0, l3;
      xfer(8'd0, 12'd0, l0, l3);
      checks++; if (l0 != 9) begin failures++; $display("FAIL zero_latency got=%0d exp=9", l0); end
      checks++; if (hex0 !== {BL, BL, BL, S0}) begin failures++; $display("FAIL zero_d0 got=%b exp=%b", hex0, {BL, BL, BL, S0}); end
      checks++; if (hex1 !== {BL, S0, S0, S0}) begin failures++; $display("FAIL zero_d1 got=%b exp=%b", hex1, {BL, S0, S0, S0}); end
      checks++; if (l3 != 13) begin failures++; $display("FAIL zero_latency_w12 got=%0d exp=13", l3); end
      checks++; if (hex3 !== {BL, BL, BL, BL, S0}) begin failures++; $display("FAIL zero_d3 got=%b exp=%b", hex3, {BL, BL, BL, BL, S0}); end
   endtask

   task automatic test_negative;
      int l0, l3;
      xfer(8'hF9, 12'hFF9, l0, l3);
      checks++; if (hex0 !== {BL, BL, MI, S7}) begin failures++; $display("FAIL neg7_d0 got=%b exp=%b", hex0, {BL, BL, MI, S7}); end
      checks++; if (hex1 !== {MI, S0, S0, S7}) begin failures++; $display("FAIL neg7_nolz got=%b exp=%b", hex1, {MI, S0, S0, S7}); end
      checks++; if (hex2 !== {BL, S2, S4, S9}) begin failures++; $display("FAIL u249 got=%b exp=%b", hex2, {BL, S2, S4, S9}); end
      checks++; if (hex3 !== {BL, BL, BL, MI, S7}) begin failures++; $display("FAIL neg7_w12 got=%b exp=%b", hex3, {BL, BL, BL, MI, S7}); end
   endtask

   task automatic test_most_negative;
      int l0, l3;
      xfer(8'h80, 12'h800, l0, l3);
      checks++; if (hex0 !== {MI, S1, S2, S8}) begin failures++; $display("FAIL neg128_d0 got=%b exp=%b", hex0, {MI, S1, S2, S8}); end
      checks++; if (hex2 !== {BL, S1, S2, S8}) begin failures++; $display("FAIL u128 got=%b exp=%b", hex2, {BL, S1, S2, S8}); end
      checks++; if (hex3 !== {MI, S2, S0, S4, S8}) begin failures++; $display("FAIL neg2048_w12 got=%b exp=%b", hex3, {MI, S2, S0, S4, S8}); end
   endtask

   task automatic test_unsigned_max;
      int l0, l3;
      xfer(8'hFF, 12'h7FF, l0, l3);
      checks++; if (hex2 !== {BL, S2, S5, S5}) begin failures++; $display("FAIL u255 got=%b exp=%b", hex2, {BL, S2, S5, S5}); end
      checks++; if (hex0 !== {BL, BL, MI, S1}) begin failures++; $display("FAIL neg1_d0 got=%b exp=%b", hex0, {BL, BL, MI, S1}); end
      checks++; if (hex3 !== {BL, S2, S0, S4, S7}) begin failures++; $display("FAIL p2047_w12 got=%b exp=%b", hex3, {BL, S2, S0, S4, S7}); end
   endtask

   task automatic test_back_to_back;
      int lat, lat2, bad_ready;
      @(negedge clk);
      in_valid = 1'b1;
      in_data8 = 8'd127;
      @(posedge clk);
      #1 in_data8 = 8'd5;
      lat = -1;
      bad_ready = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (ov0) begin lat = i; break; end
         if (rdy0) bad_ready++;
      end
      checks++; if (lat != 9) begin failures++; $display("FAIL b2b_latency got=%0d exp=9", lat); end
      checks++; if (bad_ready != 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d exp=0", bad_ready); end
      checks++; if (hex0 !== {BL, S1, S2, S7}) begin failures++; $display("FAIL b2b_first got=%b exp=%b", hex0, {BL, S1, S2, S7}); end
      checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL b2b_ready_at_ov got=%b exp=1", rdy0); end
      @(posedge clk);
      #1;
      checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL b2b_second_accept busy=%b exp=1", busy0); end
      in_valid = 1'b0;
      lat2 = -1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (ov0) begin lat2 = i; break; end
      end
      checks++; if (lat2 != 9) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=9", lat2); end
      checks++; if (hex0 !== {BL, BL, BL, S5}) begin failures++; $display("FAIL b2b_second got=%b exp=%b", hex0, {BL, BL, BL, S5}); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clk);
      in_valid = 1'b1;
      in_data8 = 8'd99;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (hex0 !== {4{BL}}) begin failures++; $display("FAIL mid_reset_hex got=%b exp=%b", hex0, {4{BL}}); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy0); end
      checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b exp=0", rdy0); end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (ov0) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL mid_reset_no_ov got=%0d exp=0", seen); end
      checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL mid_reset_ready_after got=%b exp=1", rdy0); end
      checks++; if (hex0 !== {4{BL}}) begin failures++; $display("FAIL mid_reset_hex_hold got=%b exp=%b", hex0, {4{BL}}); end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_negative();
      test_most_negative();
      test_unsigned_max();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/signed_decimal_display.md
# signed_decimal_display

Parametrised, sequential successor to the 4-bit signed 7-segment decoder. It accepts a WIDTH-bit value, signed (two's complement) or unsigned, over a valid/ready handshake. It converts the magnitude to BCD with an iterative double-dabble engine and drives DIGITS magnitude digits plus one sign digit, all active-low, with optional leading-zero blanking. It sits between the ALU/adder-subtracter datapath and the board HEX displays and holds the last result until a new conversion completes.

## Interface

- WIDTH, default 8: input width in bits, legal range 2..16.
- DIGITS, default 3: number of magnitude digits. Must be at least the decimal digit count of 2^(WIDTH-1) when SIGNED=1, or of 2^WIDTH-1 when SIGNED=0.
- SIGNED, default 1: 1 = two's complement input, 0 = unsigned input.
- BLANK_LZ, default 1: 1 = blank leading zeros and float the sign; 0 = show all digits, sign fixed in the top position.

Ports:

- clk  in  1  system clock; one clock domain; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is presented.
- in_data  in  WIDTH  value to display.
- in_ready  out  1  `(state==IDLE) & ~reset`.
- busy  out  1  high in CONVERT and FORMAT.
- out_valid  out  1  one-cycle pulse when hex updates.
- hex  out  (DIGITS+1)*7  active-low segments. Digit k occupies bits [7k+6:7k]; k=0 is least significant, k=DIGITS is the sign position. Within a digit, bit0=a through bit6=g.

## Operation

- States are IDLE, CONVERT and FORMAT.
- **IDLE.** When in_valid & in_ready, capture the operand and go to CONVERT.
  - neg = SIGNED & in_data[WIDTH-1].
  - mag = neg ? (~in_data + 1) : in_data, a WIDTH-bit unsigned value.
  - For the most negative input, mag = 2^(WIDTH-1), which is correct unsigned.
  - Clear the BCD register (4*DIGITS bits) and load the bit counter with WIDTH.
- **CONVERT.** Runs for exactly WIDTH cycles. Each cycle:
  - Add 3 to every BCD nibble that is ≥5.
  - Shift {bcd, mag} left by 1.
  - Decrement the counter; go to FORMAT when it reaches 0.
- **FORMAT.** Runs for one cycle, then goes to IDLE.
  - top = index of the highest nonzero BCD digit, or 0 if all digits are zero.
  - With BLANK_LZ=1, digits k ≤ top are shown and digits k > top are blank. The sign, when neg, goes at k = top+1; all other positions are blank.
  - With BLANK_LZ=0, all DIGITS digits are shown, and position DIGITS is the minus if neg, else blank.
  - Register hex and pulse out_valid.
- **Encodings:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Minus = 0111111; blank = 1111111.
- hex changes only in FORMAT. Between conversions it holds the last value.
- While busy, in_valid is ignored and no input is buffered.

## Timing

- Reset values:
  - hex = all ones (all digits blank).
  - out_valid = 0, busy = 0, state = IDLE.
  - in_ready = 0 while reset is high, and 1 in the first cycle after reset is released.
- Latency: for an accept at edge N, hex and out_valid update at edge N+WIDTH+1. out_valid is high for the cycle following that edge.
- in_ready is low from the accept edge until FORMAT completes. A new accept is possible in the cycle after out_valid rises, so the throughput is one conversion per WIDTH+2 cycles.
- Reset asserted mid-conversion:
  - Aborts the conversion; no out_valid is produced.
  - Blanks hex at that edge; nothing stays pending.
- in_valid high in the same cycle that reset is high is not accepted.

## Structure

- Package seg7_pkg holds:
  - segment constants SEG_DIGIT[0:9], SEG_MINUS and SEG_BLANK;
  - the state enum typedef (IDLE, CONVERT, FORMAT).
- Sub-module seg7_digit is a combinational lookup. It maps a 4-bit code to 7 segments:
  - codes 0–9 map to digits;
  - 4'hA maps to minus;
  - all other codes map to blank.
  - One instance is used per hex position, driven by FORMAT's selected codes.
- Top-level RTL holds the FSM, the double-dabble datapath, and the leading-digit detect and sign placement.

## Test plan

- **Reset, then 8'd0** (WIDTH=8, DIGITS=3): after reset, hex is all 1s and in_ready=1. Input 8'd0 gives digit0 = 1000000 and digits 1–3 blank; out_valid fires exactly 9 edges after the accept.
- **8'hF9 (-7):** digit0 = 1111000, digit1 = 0111111, digits 2–3 = 1111111.
- **8'h80 (-128):** digits 0..3 = 0000000, 0100100, 1111001, 0111111. With BLANK_LZ=0 and input 8'hF9, the result is 7, 0, 0, minus.
- **8'd127 with overlap:** send 8'd127, then hold in_valid with 8'd5 during the conversion. in_ready stays 0 and the first result is 7, 2, 1, blank. 8'd5 is accepted the cycle after out_valid, giving 5 and three blanks.
- **Reset mid-conversion:** assert reset 4 cycles into the conversion of 8'd99. hex blanks, out_valid never fires, and in_ready=1 after release.
- **Unsigned, larger width:** SIGNED=0, input 8'hFF gives 5, 5, 2, blank. WIDTH=12, DIGITS=4, input 12'h800 (-2048) gives 8, 4, 0, 2, minus.
